dpi_stream_sequencer: RTL

//  Upstream feeder for the per-regex cancid_* matcher wrappers. Accepts a byte stream of packets with a flow key,

---
 rtl/dpi_stream_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: maps each packet's flow key to a 6-bit stream ID in a
// 64-entry flow table and sequences the matcher-side restore / characters / save
// so that the three phases of a packet never overlap. All outputs are registered.
module dpi_stream_sequencer #(
    parameter int KEY_W     = 32,
    parameter int NUM_RULES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [7:0]           in_data,
    input  logic [KEY_W-1:0]     in_key,
    input  logic [NUM_RULES-1:0] cfg_enable,
    input  logic                 cfg_clear,
    output logic                 load_state,
    output logic [5:0]           stream_id,
    output logic                 new_stream_id,
    output logic [NUM_RULES-1:0] enable,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    output logic                 busy,
    output logic [15:0]          evict_cnt,
    output logic [15:0]          proto_err_cnt
);

    localparam int DEPTH = 64;

    typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, WAIT, STREAM, DRAIN, EOP} state_t;

    state_t                 state_q, state_d;

    // flow table
    logic [DEPTH-1:0]       tbl_vld;
    logic [KEY_W-1:0]       tbl_key [DEPTH];
    logic [5:0]             repl_ptr;
    logic                   clr_pend;

    // packet header captured on the sop beat
    logic [7:0]             byte_hold;
    logic [KEY_W-1:0]       key_hold;
    logic [NUM_RULES-1:0]   cfg_hold;
    logic                   one_byte;

    // lookup results
    logic                   hit, free, evict;
    logic [5:0]             hit_idx, free_idx, lk_idx;

    // next values of the registered outputs
    logic                   in_rdy_d, load_d, new_d, vld_d, eop_d, busy_d;
    logic [5:0]             sid_d;
    logic [NUM_RULES-1:0]   en_d;
    logic [7:0]             char_d;
    logic                   perr_inc;
    logic                   accept;
    logic                   clr_now;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept  = in_vld && in_rdy;
    // a pending or same-cycle clear takes effect on any IDLE cycle
    assign clr_now = (state_q == IDLE) && (clr_pend || cfg_clear);

    // Priority search: lowest matching valid entry, else lowest free entry, else round-robin victim.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl_vld[i] && (tbl_key[i] == key_hold)) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
            if (!tbl_vld[i]) begin
                free     = 1'b1;
                free_idx = 6'(i);
            end
        end
        evict  = !hit && !free;
        lk_idx = hit ? hit_idx : (free ? free_idx : repl_ptr);
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d  = state_q;
        load_d   = 1'b0;
        new_d    = 1'b0;
        vld_d    = 1'b0;
        eop_d    = 1'b0;
        char_d   = char_in;
        sid_d    = stream_id;
        en_d     = enable;
        perr_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_sop) state_d  = LOOKUP;
                    else        perr_inc = 1'b1;
                end
            end
            LOOKUP: begin
                state_d = LOAD;
                load_d  = 1'b1;
                new_d   = !hit;
                sid_d   = lk_idx;
                en_d    = cfg_hold;
            end
            LOAD: state_d = WAIT;
            WAIT: begin
                state_d = STREAM;
                char_d  = byte_hold;
                vld_d   = 1'b1;
            end
            STREAM: begin
                if (one_byte) begin
                    state_d = DRAIN;
                end else if (accept) begin
                    char_d   = in_data;
                    vld_d    = 1'b1;
                    perr_inc = in_sop;
                    if (in_eop) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // hold off eop until a cycle with no character so the last
                // character is always separated from the save pulse
                if (!char_in_vld) begin
                    state_d = EOP;
                    eop_d   = 1'b1;
                end
            end
            EOP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_rdy_d = (state_d == IDLE) || ((state_d == STREAM) && !one_byte);
        busy_d   = (state_d != IDLE);
    end

    // Control state, registered outputs, table valid bits and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            in_rdy        <= 1'b0;
            load_state    <= 1'b0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            enable        <= '0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            busy          <= 1'b0;
            evict_cnt     <= '0;
            proto_err_cnt <= '0;
            tbl_vld       <= '0;
            repl_ptr      <= '0;
            clr_pend      <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_rdy        <= in_rdy_d;
            load_state    <= load_d;
            stream_id     <= sid_d;
            new_stream_id <= new_d;
            enable        <= en_d;
            char_in       <= char_d;
            char_in_vld   <= vld_d;
            eop           <= eop_d;
            busy          <= busy_d;
            if (perr_inc) proto_err_cnt <= sat_inc(proto_err_cnt);
            if (clr_now) begin
                tbl_vld  <= '0;
                repl_ptr <= '0;
                clr_pend <= 1'b0;
            end else begin
                if (cfg_clear) clr_pend <= 1'b1;
                if ((state_q == LOOKUP) && !hit) begin
                    tbl_vld[lk_idx] <= 1'b1;
                    if (evict) begin
                        repl_ptr  <= repl_ptr + 6'd1;
                        evict_cnt <= sat_inc(evict_cnt);
                    end
                end
            end
        end
    end

    // Data-only storage: packet header capture and table keys.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && accept && in_sop) begin
            byte_hold <= in_data;
            key_hold  <= in_key;
            cfg_hold  <= cfg_enable;
            one_byte  <= in_eop;
        end
        if ((state_q == LOOKUP) && !hit) tbl_key[lk_idx] <= key_hold;
    end

endmodule
